// File: rtl/codes.sv
// Shared types for the mem_bridge CPU-to-Avalon data path.
package codes;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StDone = 2'd2
  } bus_state_t;

  // A half must sit on an even byte, a word on a multiple of four.
  function automatic logic is_misaligned(mem_size_t size, logic [1:0] offset);
    case (size)
      SizeHalf: return offset[0];
      SizeWord: return offset != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_bridge_if.sv
// CPU request/response and Avalon-MM master signals of mem_bridge.
interface mem_bridge_if;

  logic             req_i;
  logic             we_i;
  codes::mem_size_t size_i;
  logic             signed_i;
  logic [31:0]      addr_i;
  logic [31:0]      wdata_i;
  logic             busy_o;
  logic             done_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic [31:0]      avm_address_o;
  logic             avm_read_o;
  logic             avm_write_o;
  logic             avm_waitrequest_i;
  logic [31:0]      avm_writedata_o;
  logic [3:0]       avm_byteenable_o;
  logic [31:0]      avm_readdata_i;

  // The bridge itself: CPU-side slave, Avalon-side master.
  modport master (
    input  req_i, we_i, size_i, signed_i, addr_i, wdata_i,
    input  avm_waitrequest_i, avm_readdata_i,
    output busy_o, done_o, rdata_o, err_o,
    output avm_address_o, avm_read_o, avm_write_o, avm_writedata_o, avm_byteenable_o
  );

  // The environment: CPU plus Avalon memory.
  modport slave (
    output req_i, we_i, size_i, signed_i, addr_i, wdata_i,
    output avm_waitrequest_i, avm_readdata_i,
    input  busy_o, done_o, rdata_o, err_o,
    input  avm_address_o, avm_read_o, avm_write_o, avm_writedata_o, avm_byteenable_o
  );

endinterface

// File: rtl/mem_lane.sv
// Little-endian lane steering: store shift, byteenable, load extract and extension.
module mem_lane
  import codes::*;
(
  input  mem_size_t   size_i,
  input  logic        signed_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_sh;
  logic [15:0] half_sh;

  assign byte_sh = 8'(rdata_i >> {offset_i, 3'b000});
  assign half_sh = 16'(rdata_i >> {offset_i[1], 4'b0000});

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SizeByte: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = wdata_i << {offset_i, 3'b000};
        rdata_o = {{24{signed_i & byte_sh[7]}}, byte_sh};
      end
      SizeHalf: begin
        be_o    = 4'b0011 << {offset_i[1], 1'b0};
        wdata_o = wdata_i << {offset_i[1], 4'b0000};
        rdata_o = {{16{signed_i & half_sh[15]}}, half_sh};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bridge.sv
// Single-outstanding CPU load/store to Avalon-MM bridge with waitrequest timeout.
// Define MEM_ALIGN_CHECK_EN to reject misaligned HALF/WORD accesses without a bus cycle.
module mem_bridge
  import codes::*;
#(
  parameter int unsigned WAIT_LIMIT = 1024
) (
  input logic          clk,
  input logic          reset_ni,
  mem_bridge_if.master bus
);

  localparam int unsigned CntW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam logic [CntW-1:0] LimitM1 = CntW'(WAIT_LIMIT - 1);

  bus_state_t      state_q;
  logic [1:0]      offset_q;
  mem_size_t       size_q;
  logic            signed_q;
  logic            we_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [31:0]     address_q;
  logic [3:0]      be_q;
  logic [31:0]     wdata_q;
  logic            read_q;
  logic            write_q;
  logic            done_q;
  logic            err_q;
  logic [31:0]     rdata_q;

  logic            idle;
  logic            align_err;
  logic            timeout;
  mem_size_t       lane_size;
  logic [1:0]      lane_offset;
  logic [3:0]      lane_be;
  logic [31:0]     lane_wdata;
  logic [31:0]     lane_rdata;

  assign idle = (state_q == StIdle);

`ifdef MEM_ALIGN_CHECK_EN
  assign align_err = is_misaligned(bus.size_i, bus.addr_i[1:0]);
`else
  assign align_err = 1'b0;
`endif

  assign timeout = (WAIT_LIMIT != 0) && (wait_cnt_q == LimitM1);

  // One lane unit serves both phases: CPU inputs while idle, captured request during BUS.
  assign lane_size   = idle ? bus.size_i : size_q;
  assign lane_offset = idle ? bus.addr_i[1:0] : offset_q;

  mem_lane u_lane (
    .size_i   (lane_size),
    .signed_i (signed_q),
    .offset_i (lane_offset),
    .wdata_i  (bus.wdata_i),
    .rdata_i  (bus.avm_readdata_i),
    .be_o     (lane_be),
    .wdata_o  (lane_wdata),
    .rdata_o  (lane_rdata)
  );

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      offset_q   <= 2'b00;
      size_q     <= SizeByte;
      signed_q   <= 1'b0;
      we_q       <= 1'b0;
      wait_cnt_q <= '0;
      address_q  <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      read_q     <= 1'b0;
      write_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (bus.req_i) begin
            offset_q   <= bus.addr_i[1:0];
            size_q     <= bus.size_i;
            signed_q   <= bus.signed_i;
            we_q       <= bus.we_i;
            wait_cnt_q <= '0;
            if (align_err) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              address_q <= {bus.addr_i[31:2], 2'b00};
              be_q      <= lane_be;
              wdata_q   <= lane_wdata;
              read_q    <= !bus.we_i;
              write_q   <= bus.we_i;
              state_q   <= StBus;
            end
          end
        end
        StBus: begin
          if (!bus.avm_waitrequest_i) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            if (!we_q) rdata_q <= lane_rdata;
            state_q <= StDone;
          end else if (timeout) begin
            read_q  <= 1'b0;
            write_q <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= StDone;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy_o           = (state_q == StBus) || (idle && bus.req_i);
  assign bus.done_o           = done_q;
  assign bus.err_o            = err_q;
  assign bus.rdata_o          = rdata_q;
  assign bus.avm_address_o    = address_q;
  assign bus.avm_read_o       = read_q;
  assign bus.avm_write_o      = write_q;
  assign bus.avm_writedata_o  = wdata_q;
  assign bus.avm_byteenable_o = be_q;

endmodule

// File: tb/tb_mem_bridge.sv
// Scoreboard bench for mem_bridge: byte-level memory model, Avalon responder, done monitor.
module tb_mem_bridge;
  import codes::*;

  localparam int unsigned Limit = 4;

  logic clk = 1'b0;
  logic reset_ni = 1'b1;
  always #5 clk = ~clk;

  mem_bridge_if bus ();

  mem_bridge #(.WAIT_LIMIT(Limit)) dut (
    .clk      (clk),
    .reset_ni (reset_ni),
    .bus      (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [31:0] last_rdata = '0;
  logic [7:0]  bmem[logic [31:0]];
  logic [31:0] smem[logic [31:0]];

  // Avalon responder expectations for the transfer in flight
  bit          exp_bus = 0;
  bit          exp_we = 0;
  logic [31:0] exp_addr = '0;
  logic [31:0] exp_wd = '0;
  logic [3:0]  exp_be = '0;
  int          wait_left = 0;
  int          cycles_left = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] wa);
    return (wa * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (bmem.exists(a)) return bmem[a];
    w = init_word(a & ~32'd3);
    return w[a[1:0]*8 +: 8];
  endfunction

  function automatic logic [31:0] sread(input logic [31:0] wa);
    return smem.exists(wa) ? smem[wa] : init_word(wa);
  endfunction

  task automatic preload(input logic [31:0] wa, input logic [31:0] w);
    smem[wa] = w;
    for (int i = 0; i < 4; i++) bmem[wa + 32'(i)] = w[i*8 +: 8];
  endtask

  // Avalon slave: checks the command each active cycle and plays the wait pattern.
  always @(negedge clk) begin : slave
    logic [31:0] w;
    if (reset_ni) begin
      if (!exp_bus) begin
        chk("bus_idle", {30'b0, bus.avm_read_o, bus.avm_write_o}, 32'd0);
      end else begin
        chk("bus_cmd", {30'b0, bus.avm_read_o, bus.avm_write_o}, exp_we ? 32'd1 : 32'd2);
        chk("bus_addr", bus.avm_address_o, exp_addr);
        chk("bus_be", {28'b0, bus.avm_byteenable_o}, {28'b0, exp_be});
        if (exp_we) begin
          for (int i = 0; i < 4; i++) w[i*8 +: 8] = exp_be[i] ? 8'hFF : 8'h00;
          chk("bus_wdata", bus.avm_writedata_o & w, exp_wd);
        end
        cycles_left--;
        if (wait_left > 0) begin
          wait_left--;
          bus.avm_waitrequest_i = 1'b1;
          bus.avm_readdata_i    = $urandom;
        end else begin
          bus.avm_waitrequest_i = 1'b0;
          bus.avm_readdata_i    = sread(exp_addr);
          if (exp_we) begin
            w = sread(exp_addr);
            for (int i = 0; i < 4; i++)
              if (bus.avm_byteenable_o[i]) w[i*8 +: 8] = bus.avm_writedata_o[i*8 +: 8];
            smem[exp_addr] = w;
          end
        end
        if (cycles_left <= 0) exp_bus = 0;
      end
    end
  end

  // Completion monitor: every done_o pulse must match the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_ni && bus.done_o) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", {31'b0, bus.done_o}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rdata", bus.rdata_o, e.rdata);
        chk("err", {31'b0, bus.err_o}, {31'b0, e.err});
        chk("done_cycle", cyc, e.cyc);
        chk("done_cmd", {30'b0, bus.avm_read_o, bus.avm_write_o}, 32'd0);
      end
    end
  end

  task automatic issue(input bit we, input mem_size_t sz, input bit sgn,
                       input logic [31:0] addr, input logic [31:0] wd, input int waits);
    exp_t        e;
    int          nb;
    int          lane;
    logic [31:0] ea;
    logic [31:0] val;
    logic [31:0] wexp;
    logic [3:0]  be;
    bit          al_err;
    bit          tmo;
    nb = (sz == SizeByte) ? 1 : (sz == SizeHalf) ? 2 : 4;
    ea = addr & ~32'(nb - 1);
    al_err = 0;
`ifdef MEM_ALIGN_CHECK_EN
    al_err = (ea != addr);
`endif
    tmo  = !al_err && (waits >= int'(Limit));
    be   = '0;
    wexp = '0;
    val  = '0;
    for (int i = 0; i < nb; i++) begin
      lane = int'((ea + 32'(i)) & 32'd3);
      be[lane] = 1'b1;
      wexp[lane*8 +: 8] = wd[i*8 +: 8];
      val[i*8 +: 8] = ref_byte(ea + 32'(i));
    end
    if (sgn && nb < 4 && val[nb*8-1]) val = val | (32'hFFFFFFFF << (nb * 8));
    e.err   = al_err || tmo;
    e.rdata = last_rdata;
    if (!e.err) begin
      if (!we) begin
        e.rdata    = val;
        last_rdata = val;
      end else begin
        for (int i = 0; i < nb; i++) bmem[ea + 32'(i)] = wd[i*8 +: 8];
      end
    end
    @(negedge clk);
    bus.req_i    = 1'b1;
    bus.we_i     = we;
    bus.size_i   = sz;
    bus.signed_i = sgn;
    bus.addr_i   = addr;
    bus.wdata_i  = wd;
    #1 chk("busy_req", {31'b0, bus.busy_o}, 32'd1);
    @(posedge clk);
    #1;
    e.cyc = al_err ? cyc : tmo ? cyc + int'(Limit) : cyc + 1 + waits;
    exp_q.push_back(e);
    if (!al_err) begin
      exp_bus     = 1;
      exp_we      = we;
      exp_addr    = ea & ~32'd3;
      exp_be      = be;
      exp_wd      = wexp;
      wait_left   = waits;
      cycles_left = tmo ? int'(Limit) : waits + 1;
    end
    @(negedge clk);
    bus.req_i   = 1'b0;
    bus.addr_i  = $urandom;
    bus.wdata_i = $urandom;
  endtask

  task automatic wait_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
      exp_bus = 0;
    end
    @(negedge clk);
    #1 chk("busy_idle", {31'b0, bus.busy_o}, 32'd0);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin : stim
    bit          r_we;
    bit          r_sgn;
    mem_size_t   r_sz;
    logic [31:0] r_addr;
    int          r_waits;
    bus.req_i             = 1'b0;
    bus.we_i              = 1'b0;
    bus.size_i            = SizeWord;
    bus.signed_i          = 1'b0;
    bus.addr_i            = '0;
    bus.wdata_i           = '0;
    bus.avm_waitrequest_i = 1'b0;
    bus.avm_readdata_i    = '0;

    #2 reset_ni = 1'b0;
    #1;
    chk("rst_busy", {31'b0, bus.busy_o}, 32'd0);
    chk("rst_done", {31'b0, bus.done_o}, 32'd0);
    chk("rst_err", {31'b0, bus.err_o}, 32'd0);
    chk("rst_rdata", bus.rdata_o, 32'd0);
    chk("rst_rw", {30'b0, bus.avm_read_o, bus.avm_write_o}, 32'd0);
    chk("rst_addr", bus.avm_address_o, 32'd0);
    chk("rst_be", {28'b0, bus.avm_byteenable_o}, 32'd0);
    chk("rst_wdata", bus.avm_writedata_o, 32'd0);
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;

    preload(32'h1000, 32'hDEADBEEF);
    issue(0, SizeWord, 0, 32'h1000, 32'h0, 0);
    wait_done();
    chk("lw_value", bus.rdata_o, 32'hDEADBEEF);

    preload(32'h1000, 32'h80FFFFFF);
    issue(0, SizeByte, 1, 32'h1003, 32'h0, 0);
    wait_done();
    chk("lb_value", bus.rdata_o, 32'hFFFFFF80);
    issue(0, SizeByte, 0, 32'h1003, 32'h0, 0);
    wait_done();
    chk("lbu_value", bus.rdata_o, 32'h00000080);

    issue(1, SizeHalf, 0, 32'h2002, 32'h0000ABCD, 3);
    wait_done();
    issue(0, SizeHalf, 1, 32'h2002, 32'h0, 1);
    wait_done();

    issue(0, SizeWord, 0, 32'h1000, 32'h0, 20);
    wait_done();

    preload(32'h1000, 32'hDEADBEEF);
    issue(0, SizeWord, 0, 32'h1001, 32'h0, 0);
    wait_done();

    // Reset in the middle of a stalled read
    @(negedge clk);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.size_i = SizeWord;
    bus.addr_i = 32'h1000;
    @(posedge clk);
    #1;
    exp_bus     = 1;
    exp_we      = 0;
    exp_addr    = 32'h1000;
    exp_be      = 4'hF;
    wait_left   = 6;
    cycles_left = 7;
    @(negedge clk);
    bus.req_i = 1'b0;
    @(negedge clk);
    #1 reset_ni = 1'b0;
    #1;
    chk("abort_read", {31'b0, bus.avm_read_o}, 32'd0);
    chk("abort_busy", {31'b0, bus.busy_o}, 32'd0);
    chk("abort_rdata", bus.rdata_o, 32'd0);
    exp_bus    = 0;
    wait_left  = 0;
    last_rdata = '0;
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    repeat (4) @(negedge clk);
    issue(0, SizeWord, 0, 32'h1000, 32'h0, 2);
    wait_done();

    for (int k = 0; k < 60; k++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_sgn   = 1'($urandom_range(0, 1));
      r_sz    = mem_size_t'($urandom_range(0, 2));
      r_addr  = 32'h3000 + 32'($urandom_range(0, 15));
      r_waits = ($urandom_range(0, 9) == 0) ? 6 : int'($urandom_range(0, 3));
      issue(r_we, r_sz, r_sgn, r_addr, $urandom, r_waits);
      wait_done();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bridge.md
MEM_BRIDGE -- requirements
Module: mem_bridge

Interface
REQ-001 SHALL have parameter: WAIT_LIMIT, 1024, max cycles waitrequest may stay high before timeout; 0 disables timeout.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- reset_ni  in  1  asynchronous active-low reset.
- req_i  in  1  CPU access request.
- we_i  in  1  1 = store, 0 = load.
- size_i  in  2  mem_size_t: BYTE, HALF, WORD.
- signed_i  in  1  sign-extend load result.
- addr_i  in  32  byte address.
- wdata_i  in  32  store data, right-justified.
- busy_o  out  1  access in progress; CPU stalls.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  32  extended load result.
- err_o  out  1  error flag, valid with done_o.
- avm_address_o  out  32  Avalon word address.
- avm_read_o  out  1  Avalon read.
- avm_write_o  out  1  Avalon write.
- avm_waitrequest_i  in  1  Avalon stall.
- avm_writedata_o  out  32  lane-aligned store data.
- avm_byteenable_o  out  4  active byte lanes.
- avm_readdata_i  in  32  Avalon read data.

Function
REQ-003 SHALL implement FSM IDLE -> BUS -> DONE -> IDLE, state type bus_state_t.
REQ-004 IDLE: req_i=1 at a clock edge SHALL register addr, size, signed, we, lanes, and data, then enter BUS; req_i SHALL be ignored in BUS and DONE.
REQ-005 avm_address_o SHALL be {addr_i[31:2],2'b00}, registered and held constant throughout BUS.
REQ-006 Lanes SHALL be little-endian:
- BYTE: byteenable 1<<addr[1:0], data shifted 8*addr[1:0].
- HALF: byteenable 4'b0011<<addr[1], data shifted 16*addr[1].
- WORD: byteenable 4'b1111.
REQ-007 BUS SHALL assert exactly one of avm_read_o/avm_write_o, holding all avm outputs stable while avm_waitrequest_i=1.
REQ-008 The first BUS cycle with avm_waitrequest_i=0 SHALL complete the transfer; a load SHALL capture avm_readdata_i in that cycle, extract the addressed lanes, and zero- or sign-extend per signed_i into rdata_o.
REQ-009 DONE SHALL last one cycle with done_o=1, avm_read_o=avm_write_o=0; rdata_o SHALL hold until the next load completes.
REQ-010 busy_o SHALL be 1 in BUS and in the IDLE cycle where req_i=1, else 0.
REQ-011 Latency SHALL be: request accepted at edge N, bus active from N, done_o in cycle N+1+W, where W is the number of waitrequest-high cycles.
REQ-012 The wait counter SHALL count BUS cycles with waitrequest=1; on reaching WAIT_LIMIT (if nonzero) the FSM SHALL drop read/write, enter DONE with err_o=1, and leave rdata_o unchanged.
REQ-013 Stores SHALL leave rdata_o unchanged; err_o SHALL be 0 on successful completion.

Reset
REQ-014 reset_ni=0 SHALL asynchronously force: state IDLE, all avm outputs 0, busy_o=0, done_o=0, err_o=0, rdata_o=0, wait counter 0.
REQ-015 Reset asserted mid-BUS SHALL abort the transfer immediately with no done_o pulse.

Configuration
REQ-016 With MEM_ALIGN_CHECK_EN defined: HALF with addr[0]=1 or WORD with addr[1:0]!=0 SHALL issue no bus cycle and go IDLE->DONE with err_o=1.
REQ-017 Without MEM_ALIGN_CHECK_EN: HALF SHALL ignore addr[0], WORD SHALL ignore addr[1:0], and err_o SHALL arise only from timeout.

Structure
REQ-018 mem_size_t and bus_state_t SHALL be defined in the shared package codes.
REQ-019 Lane shift, byteenable generation, and load extract/extension SHALL be a combinational sub-module mem_lane.

Verification
REQ-020 The bench SHALL cover:
- LW at 0x1000, waitrequest 0, readdata 0xDEADBEEF -> address 0x1000, byteenable 1111, done_o at N+1, rdata_o=0xDEADBEEF.
- LB signed at 0x1003, readdata 0x80FFFFFF -> byteenable 1000, rdata_o=0xFFFFFF80; with LBU -> 0x00000080.
- SH at 0x2002, wdata 0x0000ABCD, waitrequest high 3 cycles -> byteenable 1100, writedata[31:16]=0xABCD held stable 4 cycles, done_o at N+4.
- WAIT_LIMIT=4, waitrequest stuck high -> read drops after 4 cycles, done_o=1 with err_o=1.
- With MEM_ALIGN_CHECK_EN, LW at 0x1001 -> no avm_read_o, done_o with err_o=1; without the macro -> normal read of 0x1000.
- reset_ni pulsed low mid-BUS -> avm_read_o=0 same cycle, no done_o, next request accepted normally.
